// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the fetch stage and its helpers.
// Instruction codes, status codes, register ids and the fetch state enum.
package y86_pkg;

  localparam logic [3:0] INOP    = 4'h0;
  localparam logic [3:0] IHALT   = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StIssue,
    StCommit,
    StStop
  } fetch_state_e;

endpackage

// File: rtl/fetch_split.sv
// Combinational splitter: turns a 10-byte instruction window into Y86-64 fields and valP.
module fetch_split
  import y86_pkg::*;
(
  input  logic [63:0] pc_i,
  input  logic [79:0] window_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic [63:0] valp_o,
  output logic        need_regids_o,
  output logic        need_valc_o
);

  always_comb begin
    icode_o       = window_i[7:4];
    ifun_o        = window_i[3:0];
    need_regids_o = icode_o inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHL, IPOPL};
    need_valc_o   = icode_o inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    ra_o          = RNONE;
    rb_o          = RNONE;
    valc_o        = '0;
    if (need_regids_o) begin
      ra_o = window_i[15:12];
      rb_o = window_i[11:8];
    end
    // The constant shifts up by one byte when a register byte is present.
    if (need_valc_o) begin
      valc_o = need_regids_o ? window_i[79:16] : window_i[71:8];
    end
    valp_o = pc_i + 64'd1 + {63'd0, need_regids_o} + (need_valc_o ? 64'd8 : 64'd0);
  end

endmodule

// File: rtl/fetch_seq.sv
// Y86-64 SEQ fetch stage: one imem read per instruction, handshake to decode,
// then waits for the write-back commit before choosing the next PC.
module fetch_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [79:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic [2:0]  stat_o,
  input  logic        wb_valid_i,
  input  logic        wb_cnd_i,
  input  logic [63:0] wb_valM_i,
  output logic [63:0] pc_o,
  output logic        halted_o
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]   icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0]  valc_q, valc_d, valp_q, valp_d;
  logic [2:0]   stat_q, stat_d;

  logic [3:0]   sp_icode, sp_ifun, sp_ra, sp_rb;
  logic [63:0]  sp_valc, sp_valp;
  logic         sp_need_regids, sp_need_valc;
  logic         unused_need;

  fetch_split u_split (
    .pc_i         (pc_q),
    .window_i     (imem_rdata_i),
    .icode_o      (sp_icode),
    .ifun_o       (sp_ifun),
    .ra_o         (sp_ra),
    .rb_o         (sp_rb),
    .valc_o       (sp_valc),
    .valp_o       (sp_valp),
    .need_regids_o(sp_need_regids),
    .need_valc_o  (sp_need_valc)
  );

  assign unused_need = sp_need_regids ^ sp_need_valc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    icode_d    = icode_q;
    ifun_d     = ifun_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    valc_d     = valc_q;
    valp_d     = valp_q;
    stat_d     = stat_q;
    unique case (state_q)
      StReq: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (imem_ack_i) begin
          icode_d = sp_icode;
          ifun_d  = sp_ifun;
          ra_d    = sp_ra;
          rb_d    = sp_rb;
          valc_d  = sp_valc;
          valp_d  = sp_valp;
          if (imem_err_i)            stat_d = SADR;
          else if (sp_icode > IPOPL) stat_d = SINS;
          else if (sp_icode == IHALT) stat_d = SHLT;
          else                       stat_d = SAOK;
          state_d = StIssue;
        end else if (wait_cnt_q == WaitLast) begin
          // Memory never answered: report a clean ADR bubble at this PC.
          icode_d = INOP;
          ifun_d  = 4'h0;
          ra_d    = RNONE;
          rb_d    = RNONE;
          valc_d  = '0;
          valp_d  = pc_q;
          stat_d  = SADR;
          state_d = StIssue;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StIssue: begin
        if (ready_i) state_d = (stat_q == SAOK) ? StCommit : StStop;
      end
      StCommit: begin
        if (wb_valid_i) begin
          state_d = StReq;
          if (icode_q == ICALL)     pc_d = valc_q;
          else if (icode_q == IJXX) pc_d = wb_cnd_i ? valc_q : valp_q;
          else if (icode_q == IRET) pc_d = wb_valM_i;
          else                      pc_d = valp_q;
        end
      end
      StStop: begin
        state_d = StStop;
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      icode_q    <= 4'h0;
      ifun_q     <= 4'h0;
      ra_q       <= RNONE;
      rb_q       <= RNONE;
      valc_q     <= '0;
      valp_q     <= '0;
      stat_q     <= SAOK;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      icode_q    <= icode_d;
      ifun_q     <= ifun_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      valc_q     <= valc_d;
      valp_q     <= valp_d;
      stat_q     <= stat_d;
    end
  end

  assign imem_req_o  = (state_q == StReq) || (state_q == StWait);
  assign imem_addr_o = pc_q;
  assign valid_o     = (state_q == StIssue);
  assign halted_o    = (state_q == StStop);
  assign pc_o        = pc_q;
  assign icode_o     = icode_q;
  assign ifun_o      = ifun_q;
  assign rA_o        = ra_q;
  assign rB_o        = rb_q;
  assign valC_o      = valc_q;
  assign valP_o      = valp_q;
  assign stat_o      = stat_q;

endmodule
